// File: rtl/rca_pkg.sv
// Shared constants for the ripple-carry adder family.
package rca_pkg;
  localparam int ADD_W = 4;
endpackage

// File: rtl/four_bit_adder_if.sv
// Operand/result bundle for four_bit_adder: master supplies operands, slave returns a registered result.
interface four_bit_adder_if;
  import rca_pkg::*;

  logic [ADD_W-1:0] A;
  logic [ADD_W-1:0] B;
  logic             CarryIn;
  logic             in_valid;
  logic [ADD_W-1:0] sum;
  logic             carryout;
  logic             out_valid;

  modport master (
    output A, B, CarryIn, in_valid,
    input  sum, carryout, out_valid
  );

  modport slave (
    input  A, B, CarryIn, in_valid,
    output sum, carryout, out_valid
  );
endinterface

// File: rtl/full_adder.sv
// Gate-level 1-bit full adder; combinational, no backpressure.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);
endmodule

// File: rtl/four_bit_adder.sv
// Registered 4-bit ripple-carry adder; latency 1 cycle, accepts one operand set per cycle.
// No backpressure: every in_valid cycle is captured; rst wins over in_valid.
module four_bit_adder
  import rca_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  four_bit_adder_if.slave  bus
);
  logic [ADD_W:0]   c;
  logic [ADD_W-1:0] s;

  assign c[0] = bus.CarryIn;

  // Carry strictly ripples bit to bit; c[ADD_W] is the critical path into carryout.
  for (genvar i = 0; i < ADD_W; i++) begin : g_fa
    full_adder u_fa (
      .a    (bus.A[i]),
      .b    (bus.B[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.sum       <= '0;
      bus.carryout  <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.sum      <= s;
        bus.carryout <= c[ADD_W];
      end
    end
  end
endmodule

// File: tb/tb_four_bit_adder.sv
// Bench for four_bit_adder: directed cases, exhaustive sweep and random traffic vs an arithmetic model.
module tb_four_bit_adder;
  logic clk = 1'b0;
  logic rst;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: what the outputs must read after each edge.
  logic [3:0] exp_sum;
  logic       exp_cout;
  logic       exp_vld;

  four_bit_adder_if bus ();

  four_bit_adder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, then check all outputs.
  task automatic step(input int a, input int b, input int ci, input bit v, input bit r,
                      input string tag);
    int total;
    bus.A        = 4'(a);
    bus.B        = 4'(b);
    bus.CarryIn  = ci[0];
    bus.in_valid = v;
    rst          = r;
    @(posedge clk);
    #1;
    total = a + b + ci;
    if (r) begin
      exp_sum  = 4'd0;
      exp_cout = 1'b0;
      exp_vld  = 1'b0;
    end else begin
      exp_vld = v;
      if (v) begin
        exp_sum  = 4'(total % 16);
        exp_cout = (total >= 16);
      end
    end
    chk({tag, ".sum"},       8'(bus.sum),       8'(exp_sum));
    chk({tag, ".carryout"},  8'(bus.carryout),  8'(exp_cout));
    chk({tag, ".out_valid"}, 8'(bus.out_valid), 8'(exp_vld));
  endtask

  initial begin
    rst          = 1'b1;
    bus.A        = 4'hF;
    bus.B        = 4'hF;
    bus.CarryIn  = 1'b0;
    bus.in_valid = 1'b1;

    // Reset with live operands must discard them.
    step(15, 15, 0, 1'b1, 1'b1, "reset0");
    step(15, 15, 0, 1'b1, 1'b1, "reset1");

    step(4'b1001, 4'b1011, 0, 1'b1, 1'b0, "basic");
    step(4'b1111, 4'b1000, 1, 1'b1, 1'b0, "cin_path");
    step(4'b1111, 4'b0000, 1, 1'b1, 1'b0, "ripple_all");
    step(4'b0111, 4'b0001, 0, 1'b1, 1'b0, "ripple_lo");

    // Fixed expectations for the directed cases, independent of the model.
    step(4'b0011, 4'b0100, 0, 1'b1, 1'b0, "hold_cap");
    chk("hold_cap.const", 8'(bus.sum), 8'h07);
    step(4'b1110, 4'b1101, 1, 1'b0, 1'b0, "hold0");
    step(4'b0101, 4'b1010, 0, 1'b0, 1'b0, "hold1");
    chk("hold.const", 8'(bus.sum), 8'h07);

    // Exhaustive back-to-back sweep, with one reset cycle inserted mid-stream.
    for (int i = 0; i < 512; i++) begin
      if (i == 300) begin
        step(15, 15, 1, 1'b1, 1'b1, "sweep_rst");
        chk("sweep_rst.const", 8'({bus.carryout, bus.sum}), 8'h00);
      end
      step(i % 16, (i / 16) % 16, i / 256, 1'b1, 1'b0, "sweep");
    end

    // Random traffic with gaps in in_valid and occasional resets.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1),
           $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/four_bit_adder.md
# four_bit_adder

Registered 4-bit ripple-carry adder with carry-in and carry-out. Built from a chain of four gate-level full adders whose result is captured in an output register stage. Serves as the basic arithmetic leaf used by wider adders and ALU datapaths in the RCA family.

## Interface

- Parameters: none. Operand width is fixed at 4 bits by the package constant `ADD_W = 4`.
- One clock; reset is synchronous and active-high.
- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous active-high reset
- `A`  input  4  operand A, unsigned
- `B`  input  4  operand B, unsigned
- `CarryIn`  input  1  carry into bit 0
- `in_valid`  input  1  operands valid this cycle; result is captured on this edge
- `sum`  output  4  registered sum bits [3:0]
- `carryout`  output  1  registered carry out of bit 3
- `out_valid`  output  1  `sum`/`carryout` hold a freshly captured result

## Operation

- Combinational core: {c4, s[3:0]} = A + B + CarryIn, computed strictly as a ripple.
  - c0 = CarryIn.
  - si = Ai ^ Bi ^ ci.
  - ci+1 = (Ai & Bi) | (ci & (Ai ^ Bi)).
- No lookahead logic. Unsigned arithmetic only; no overflow or signed flag.
- Output register:
  - On a clock edge with `rst`=0 and `in_valid`=1, capture `sum`<=s and `carryout`<=c4.
  - On a clock edge with `in_valid`=0, `sum` and `carryout` hold their previous values.
  - `out_valid` is registered from `in_valid` on every non-reset edge.
- No backpressure; a new operand set is accepted every cycle.
- Input X/Z handling is undefined; the bench drives only known values.

## Timing

- Latency 1 cycle: operands sampled at edge N appear on the outputs after edge N.
- Throughput 1 result per cycle.
- Reset values: `sum`=4'b0000, `carryout`=0, `out_valid`=0.
- `rst` overrides `in_valid` on the same edge; an operand presented with `rst`=1 is discarded.
- Reset mid-stream clears the outputs on the next edge. The first valid result after reset arrives one edge after `in_valid` is sampled high with `rst`=0.
- Boundary case: all-ones plus carry-in (worst-case ripple through all four stages) must settle within one clock period. The critical path is CarryIn through c1..c4 into the `carryout` register.

## Structure

- Shared package `rca_pkg`: constant `ADD_W = 4`.
- Sub-module `full_adder`, gate-level XOR/AND/OR.
  - Ports: a, b, cin, s, cout.
  - Instantiated four times with the carry chained c0 to c4.
- Top level `four_bit_adder`: the four `full_adder` instances plus the output register process. No other logic.

## Test plan

1. Reset: hold `rst`=1 for 2 cycles with A=4'b1111, B=4'b1111, `in_valid`=1 -> `sum`=0000, `carryout`=0, `out_valid`=0.
2. Basic add: A=1001, B=1011, CarryIn=0, `in_valid`=1 -> next cycle `sum`=0100, `carryout`=1, `out_valid`=1.
3. Carry-in path: A=1111, B=1000, CarryIn=1 -> `sum`=1000, `carryout`=1.
4. Full ripple: A=1111, B=0000, CarryIn=1 -> `sum`=0000, `carryout`=1. Also A=0111, B=0001, CarryIn=0 -> `sum`=1000, `carryout`=0.
5. Hold: capture A=0011, B=0100, CarryIn=0 (`sum`=0111), then drop `in_valid` and change operands -> `sum` stays 0111, `out_valid`=0.
6. Exhaustive sweep: all 512 combinations of A, B and CarryIn streamed back-to-back -> each result equals A+B+CarryIn one cycle later. Also assert `rst` mid-stream -> outputs read 0 on the next edge.
